interrupt_controller: RTL
=========================

# interrupt_controller

Collects external interrupt lines for the Mini SRC datapath, synchronizes and edge-detects them, and latches them as pending requests. It masks the pending requests and picks one by fixed priority. It presents that one request to the control unit on its `interrupt` input vector and holds it until the control unit acknowledges. It sits directly upstream of the control unit. It also exposes a cause word that the ISR reads over the bus.

## Interface
- `InterruptsNum`, default 2: number of interrupt lines. Legal range is 1..32.
- `Clock`, in, 1: single clock. All state updates on the rising edge.
- `Reset`, in, 1: asynchronous, active-low reset. Low clears all state immediately.
- `irq`, in, InterruptsNum: raw external request lines. Asynchronous to `Clock`, level-high.
- `MaskIn`, in, 1: load the mask register from `BusMuxOut[InterruptsNum-1:0]`.
- `BusMuxOut`, in, 32: datapath bus.
- `IntAck`, in, 1: control unit accepts the presented request. One cycle pulse.
- `IntReturn`, in, 1: control unit finished the ISR. One cycle pulse.
- `interrupt`, out, InterruptsNum: one-hot request to the control unit.
- `IntActive`, out, 1: high in REQ and SERVICE.
- `Cause`, out, 32: `{IntActive, 23'b0, grant_id[7:0]}`.
- `MaskOut`, out, 32: mask register, zero-extended.

## Operation
- Synchronizer, per line:
  - Three-flop chain `s1 <= irq`, `s2 <= s1`, `s3 <= s2`.
  - Rising-edge detect `edge = s2 & ~s3`.
- Pending register: `pending <= (pending & ~clr) | edge`.
  - `clr` is the one-hot grant, asserted only on the cycle an `IntAck` is accepted.
  - Set wins over clear on the same bit in the same cycle.
  - Level-held `irq` produces exactly one pending event per rising transition.
- Mask:
  - On `MaskIn`, `mask <= BusMuxOut[InterruptsNum-1:0]`. Upper bus bits are ignored.
  - Reset value is all ones, i.e. all lines enabled.
  - Masking does not clear pending bits. A pending bit that is masked stays latched and becomes eligible when it is unmasked.
- Eligible requests: `eligible = pending & mask`.
- Priority: the lowest index wins, so bit 0 is highest.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE:
    - If `eligible != 0`, latch `grant_id` = lowest set index and go to REQ.
    - Otherwise stay in IDLE.
  - REQ:
    - `interrupt = 1 << grant_id`.
    - On `IntAck`, clear `pending[grant_id]`, go to SERVICE, and drop `interrupt` to 0 on the next cycle.
    - The grant is frozen while in REQ. Newer higher-priority requests and mask writes do not change `grant_id` or withdraw the request.
  - SERVICE:
    - `interrupt = 0`.
    - On `IntReturn`, go to IDLE.
    - No nesting: new edges still accumulate in `pending` but are not presented.
- Ignored and simultaneous inputs:
  - `IntAck` is ignored in IDLE and SERVICE.
  - `IntReturn` is ignored in IDLE and REQ.
  - If `IntAck` and `IntReturn` arrive together in REQ, the ack is taken and the state goes to SERVICE.
- `grant_id` holds its value through SERVICE, so `Cause` stays valid for the ISR. It returns to 0 on entry to IDLE.

## Timing
- Reset values:
  - State is IDLE.
  - `s1`, `s2`, `s3` = 0; `pending` = 0; `mask` = all ones; `grant_id` = 0.
  - Outputs: `interrupt` = 0, `IntActive` = 0, `Cause` = 0, `MaskOut` = all ones (zero-extended).
- Reset mid-operation: any pending or in-service request is discarded. No output glitches high after reset deasserts.
- Latency from `irq` to pending: `irq` first sampled high at edge k means `pending` is set after edge k+3.
- Latency from pending to request: state reaches REQ after edge k+4, and `interrupt` is driven from a register, valid after that edge. It is stable across the control unit's negedge sampling.
- Acknowledge: `IntAck` sampled at an edge ends REQ at that edge, and `interrupt` is 0 after it.
- Return: REQ is re-entered at the earliest one edge after the IDLE edge.
- A mask write takes effect for arbitration on the next edge.
- All outputs are registered or decoded from registers only. There is no combinational path from inputs to outputs.

## Test plan
- Reset check: hold `Reset` low, pulse `irq` = 2'b11, then release reset.
  - Required: `interrupt` = 0, `MaskOut` = 0x3, `Cause` = 0, and no request appears until a new edge arrives.
- Single request: raise `irq[1]` and hold it high.
  - `pending[1]` is set after edge k+3 and `interrupt` = 2'b10 after edge k+4.
  - `Cause` = 0x80000001.
  - An `IntAck` pulse leads to `interrupt` = 0 and `IntActive` = 1.
  - An `IntReturn` pulse leads to `Cause` = 0 and no re-request while `irq[1]` stays high.
- Priority: raise `irq` 2'b11 on the same edge.
  - The grant goes to 0, with `interrupt` = 2'b01.
  - After ack and return, `interrupt` = 2'b10 is presented.
- Masking: write `BusMuxOut` = 0x2 with `MaskIn`, then edge `irq[0]`.
  - No request is presented, and `pending[0]` = 1.
  - Write the mask back to 0x3: `interrupt` = 2'b01 two edges later.
- Frozen grant: while in REQ for line 1, edge `irq[0]` and clear the mask.
  - `interrupt` stays 2'b10 until `IntAck`.
  - Line 0 is presented only after return and after it is unmasked.
- Set-over-clear: edge `irq[0]` timed so that its edge pulse coincides with `IntAck` for grant 0.
  - `pending[0]` remains 1, and line 0 is re-presented after `IntReturn`.
- Async reset in SERVICE: drop `Reset` between clock edges.
  - State, `pending` and `Cause` are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// -----------------------------------------------------------------------------
// interrupt_controller_if
// Groups the request, mask-bus and control-unit handshake signals of the
// interrupt controller.
//   irq        : raw asynchronous request lines (level-high)
//   MaskIn     : load mask register from BusMuxOut
//   BusMuxOut  : 32-bit datapath bus
//   IntAck     : control unit accepts the presented request (pulse)
//   IntReturn  : control unit finished the ISR (pulse)
//   interrupt  : one-hot request presented to the control unit
//   IntActive  : a request is presented or being serviced
//   Cause      : {IntActive, 23'b0, grant_id[7:0]}
//   MaskOut    : mask register, zero-extended
// master = control unit / bus side, slave = interrupt controller.
// -----------------------------------------------------------------------------
interface interrupt_controller_if #(
  parameter int InterruptsNum = 2
);
  logic [InterruptsNum-1:0] irq;
  logic                     MaskIn;
  logic [31:0]              BusMuxOut;
  logic                     IntAck;
  logic                     IntReturn;
  logic [InterruptsNum-1:0] interrupt;
  logic                     IntActive;
  logic [31:0]              Cause;
  logic [31:0]              MaskOut;

  modport master (
    output irq, MaskIn, BusMuxOut, IntAck, IntReturn,
    input  interrupt, IntActive, Cause, MaskOut
  );

  modport slave (
    input  irq, MaskIn, BusMuxOut, IntAck, IntReturn,
    output interrupt, IntActive, Cause, MaskOut
  );
endinterface

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
// Synchronizes and edge-detects external interrupt lines, latches them as
// pending requests, masks them, and presents the lowest-index eligible request
// to the control unit until it is acknowledged. No nesting: a new request is
// only presented after the control unit returns from the ISR.
// Ports:
//   Clock : single clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : interrupt_controller_if.slave (irq, mask bus, handshake, outputs)
// -----------------------------------------------------------------------------
module interrupt_controller #(
  parameter int InterruptsNum = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  interrupt_controller_if.slave bus
);

  localparam int N = InterruptsNum;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t       state_r;
  state_t       state_s;
  logic [N-1:0] s1_r;
  logic [N-1:0] s2_r;
  logic [N-1:0] s3_r;
  logic [N-1:0] edge_r;
  logic [N-1:0] pending_r;
  logic [N-1:0] pending_s;
  logic [N-1:0] mask_r;
  logic [N-1:0] eligible_s;
  logic [N-1:0] clr_s;
  logic [4:0]   grant_id_r;
  logic [4:0]   grant_id_s;
  logic         active_s;
  logic         unused_bus_s;

  // Lowest set index of v (bit 0 has highest priority); 0 when v is empty.
  function automatic logic [4:0] lowest_index(input logic [N-1:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = v[i] ? 5'(i) : idx;
    end
    return idx;
  endfunction

  // One-hot vector with only bit id set.
  function automatic logic [N-1:0] onehot(input logic [4:0] id);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      v[i] = (5'(i) == id);
    end
    return v;
  endfunction

  // Upper bus bits are intentionally ignored by the mask load.
  assign unused_bus_s = ^bus.BusMuxOut;

  // Synchronizer chain plus registered rising-edge pulse.  Registering the
  // pulse places the pending set three edges after irq is first sampled.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      s1_r   <= '0;
      s2_r   <= '0;
      s3_r   <= '0;
      edge_r <= '0;
    end else begin
      s1_r   <= bus.irq;
      s2_r   <= s1_r;
      s3_r   <= s2_r;
      edge_r <= s2_r & ~s3_r;
    end
  end

  // Pending set/clear: a new edge on the granted bit wins over the ack clear.
  always_comb begin
    pending_s  = (pending_r & ~clr_s) | edge_r;
    eligible_s = pending_r & mask_r;
  end

  // Pending and mask registers; masking never clears pending bits.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pending_r <= '0;
      mask_r    <= '1;
    end else begin
      pending_r <= pending_s;
      if (bus.MaskIn) begin
        mask_r <= bus.BusMuxOut[N-1:0];
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // Next-state logic: the grant is frozen from IDLE exit until return.
  always_comb begin
    state_s    = state_r;
    grant_id_s = grant_id_r;
    clr_s      = '0;
    case (state_r)
      IDLE: begin
        if (|eligible_s) begin
          state_s    = REQ;
          grant_id_s = lowest_index(eligible_s);
        end else begin
          state_s    = IDLE;
        end
      end
      REQ: begin
        // Ack has precedence over a simultaneous return.
        if (bus.IntAck) begin
          state_s = SERVICE;
          clr_s   = onehot(grant_id_r);
        end else begin
          state_s = REQ;
        end
      end
      SERVICE: begin
        if (bus.IntReturn) begin
          state_s    = IDLE;
          grant_id_s = 5'd0;
        end else begin
          state_s    = SERVICE;
        end
      end
      default: begin
        state_s    = IDLE;
        grant_id_s = 5'd0;
      end
    endcase
  end

  // State and grant registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r    <= IDLE;
      grant_id_r <= 5'd0;
    end else begin
      state_r    <= state_s;
      grant_id_r <= grant_id_s;
    end
  end

  // Outputs are decoded from registers only, so they are stable all cycle.
  always_comb begin
    active_s = (state_r == REQ) || (state_r == SERVICE);
    if (state_r == REQ) begin
      bus.interrupt = onehot(grant_id_r);
    end else begin
      bus.interrupt = '0;
    end
    bus.IntActive = active_s;
    bus.Cause     = {active_s, 23'd0, 3'd0, grant_id_r};
    bus.MaskOut   = 32'(mask_r);
  end

endmodule
